// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// spi_pkg : shared types for the multi-slave SPI master
// Rev 1.0 : initial release
// ============================================================================
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        HOLD  = 2'd3
    } spi_state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    localparam spi_mode_t SPI_MODE0 = '{cpol: 1'b0, cpha: 1'b0};
    localparam spi_mode_t SPI_MODE1 = '{cpol: 1'b0, cpha: 1'b1};
    localparam spi_mode_t SPI_MODE2 = '{cpol: 1'b1, cpha: 1'b0};
    localparam spi_mode_t SPI_MODE3 = '{cpol: 1'b1, cpha: 1'b1};

endpackage
`default_nettype wire

// File: rtl/spi_clk_gen.sv
`default_nettype none
// ============================================================================
// spi_clk_gen : half-period counter, one-cycle tick every i_div+1 clocks
// Rev 1.0 : initial release
// ============================================================================
module spi_clk_gen #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_restart,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == i_div);
    assign o_tick = w_wrap && !i_restart;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_restart || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_master_multi.sv
`default_nettype none
// ============================================================================
// spi_master_multi : SPI master, run-time CPOL/CPHA, divider and slave select
// Optional: define SPI_LSB_FIRST_EN to add the lsb_first input.
// Rev 1.0 : initial release
// ============================================================================
module spi_master_multi
    import spi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NUM_CS = 4,
    parameter int DIV_W  = 8,
    localparam int CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [DIV_W-1:0]  clk_div,
`ifdef SPI_LSB_FIRST_EN
    input  logic              lsb_first,
`endif
    output logic              busy,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_CS-1:0] cs_n,
    output logic [DATA_W-1:0] rx_data,
    output logic              done
);

    localparam int              EDGE_W       = $clog2(2 * DATA_W + 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST_M1 = EDGE_W'(2 * DATA_W - 1);

    spi_state_t        r_state;
    spi_state_t        w_next_state;
    spi_mode_t         r_mode;
    logic [DIV_W-1:0]  r_div;
    logic [DATA_W-1:0] r_tx;
    logic [DATA_W-1:0] r_rx;
    logic [EDGE_W-1:0] r_edge_cnt;
    logic              r_sclk;
    logic              r_mosi;
    logic [NUM_CS-1:0] r_cs_n;
    logic [DATA_W-1:0] r_rx_data;
    logic              r_done;
    logic              r_busy;

    logic              w_accept;
    logic              w_tick;
    logic              w_lead;
    logic              w_last;
    logic              w_edge;
    logic              w_sample;
    logic              w_shift;
    logic              w_finish;
    logic              w_lsb;
    logic              w_lsb_in;
    logic [NUM_CS-1:0] w_cs_dec;

`ifdef SPI_LSB_FIRST_EN
    logic r_lsb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lsb <= 1'b0;
        end else if (w_accept) begin
            r_lsb <= lsb_first;
        end
    end

    assign w_lsb    = r_lsb;
    assign w_lsb_in = lsb_first;
`else
    assign w_lsb    = 1'b0;
    assign w_lsb_in = 1'b0;
`endif

    function automatic logic f_first_bit(input logic [DATA_W-1:0] v, input logic lsb);
        return lsb ? v[0] : v[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] f_shift_tx(input logic [DATA_W-1:0] v, input logic lsb);
        return lsb ? {1'b0, v[DATA_W-1:1]} : {v[DATA_W-2:0], 1'b0};
    endfunction

    function automatic logic [DATA_W-1:0] f_shift_rx(input logic [DATA_W-1:0] v, input logic lsb,
                                                     input logic b_in);
        return lsb ? {b_in, v[DATA_W-1:1]} : {v[DATA_W-2:0], b_in};
    endfunction

    // Out-of-range cs_sel matches no index, so every line stays high.
    generate
        for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_cs_dec
            assign w_cs_dec[gi] = (cs_sel != CS_W'(gi));
        end
    endgenerate

    assign w_accept = (r_state == IDLE) && start && !r_busy;
    assign w_lead   = (r_edge_cnt[0] == 1'b0);
    assign w_last   = (r_edge_cnt == EDGE_LAST_M1);

    spi_clk_gen #(
        .DIV_W (DIV_W)
    ) u_clk_gen (
        .clk       (clk),
        .rst       (rst),
        .i_restart (w_accept),
        .i_div     (r_div),
        .o_tick    (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept)          w_next_state = SETUP;
            SETUP:   if (w_tick)            w_next_state = XFER;
            XFER:    if (w_tick && w_last)  w_next_state = HOLD;
            HOLD:    if (w_tick)            w_next_state = IDLE;
            default:                        w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_edge   = 1'b0;
        w_sample = 1'b0;
        w_shift  = 1'b0;
        w_finish = 1'b0;
        case (r_state)
            XFER: begin
                if (w_tick) begin
                    w_edge = 1'b1;
                    if (r_mode.cpha) begin
                        w_shift  = w_lead;
                        w_sample = !w_lead;
                    end else begin
                        // The final trailing edge has no further bit to present.
                        w_sample = w_lead;
                        w_shift  = !w_lead && !w_last;
                    end
                end
            end
            HOLD:    w_finish = w_tick;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode     <= SPI_MODE0;
            r_div      <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_edge_cnt <= '0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_cs_n     <= '1;
            r_rx_data  <= '0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_done <= w_finish;

            // busy covers the done cycle, so a start there waits one cycle.
            if (w_accept) begin
                r_busy <= 1'b1;
            end else if (r_done) begin
                r_busy <= 1'b0;
            end

            if (r_state == IDLE) begin
                r_sclk <= cpol;
            end else if (w_edge) begin
                r_sclk <= ~r_sclk;
            end else if (r_state != XFER) begin
                r_sclk <= r_mode.cpol;
            end

            if (w_accept) begin
                r_mode     <= '{cpol: cpol, cpha: cpha};
                r_div      <= clk_div;
                r_cs_n     <= w_cs_dec;
                r_edge_cnt <= '0;
                r_rx       <= '0;
                if (!cpha) begin
                    r_mosi <= f_first_bit(tx_data, w_lsb_in);
                    r_tx   <= f_shift_tx(tx_data, w_lsb_in);
                end else begin
                    r_tx   <= tx_data;
                end
            end

            if (w_edge) begin
                r_edge_cnt <= r_edge_cnt + EDGE_W'(1);
            end

            if (w_shift) begin
                r_mosi <= f_first_bit(r_tx, w_lsb);
                r_tx   <= f_shift_tx(r_tx, w_lsb);
            end

            if (w_sample) begin
                r_rx <= f_shift_rx(r_rx, w_lsb, miso);
            end

            if (w_finish) begin
                r_cs_n    <= '1;
                r_rx_data <= r_rx;
            end
        end
    end

    assign busy    = r_busy;
    assign sclk    = r_sclk;
    assign mosi    = r_mosi;
    assign cs_n    = r_cs_n;
    assign rx_data = r_rx_data;
    assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_multi.sv
`default_nettype none
// ============================================================================
// tb_spi_master_multi : directed, table-driven bench for spi_master_multi
// Rev 1.0 : initial release
// ============================================================================
module tb_spi_master_multi;
    import spi_pkg::*;

    // Five chip selects so an out-of-range cs_sel (5) is encodable in 3 bits.
    localparam int DATA_W = 8;
    localparam int NUM_CS = 5;
    localparam int DIV_W  = 8;
    localparam int CS_W   = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [DATA_W-1:0] tx_data;
    logic [CS_W-1:0]   cs_sel;
    logic              cpol;
    logic              cpha;
    logic [DIV_W-1:0]  clk_div;
    logic              busy;
    logic              sclk;
    logic              mosi;
    logic              miso;
    logic [NUM_CS-1:0] cs_n;
    logic [DATA_W-1:0] rx_data;
    logic              done;
`ifdef SPI_LSB_FIRST_EN
    logic              lsb_first;
`endif

    logic              loop_en;
    logic [7:0]        slave_word;
    logic [7:0]        r_slv_sh;
    logic [7:0]        r_slv_cap;
    logic              r_slv_miso;
    logic              w_cs_any;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    spi_master_multi #(
        .DATA_W (DATA_W),
        .NUM_CS (NUM_CS),
        .DIV_W  (DIV_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .tx_data   (tx_data),
        .cs_sel    (cs_sel),
        .cpol      (cpol),
        .cpha      (cpha),
        .clk_div   (clk_div),
`ifdef SPI_LSB_FIRST_EN
        .lsb_first (lsb_first),
`endif
        .busy      (busy),
        .sclk      (sclk),
        .mosi      (mosi),
        .miso      (miso),
        .cs_n      (cs_n),
        .rx_data   (rx_data),
        .done      (done)
    );

    // Mode-3 slave: drives on falling (leading) edge, captures on rising.
    assign w_cs_any = ~&cs_n;
    assign miso     = loop_en ? mosi : r_slv_miso;

    initial r_slv_miso = 1'b0;

    always @(posedge w_cs_any) begin
        r_slv_sh  = slave_word;
        r_slv_cap = 8'h00;
    end

    always @(negedge sclk) begin
        if (w_cs_any) begin
            r_slv_miso = r_slv_sh[7];
            r_slv_sh   = {r_slv_sh[6:0], 1'b0};
        end
    end

    always @(posedge sclk) begin
        if (w_cs_any) r_slv_cap = {r_slv_cap[6:0], mosi};
    end

    typedef struct {
        spi_mode_t  mode;
        logic [7:0] div;
        logic [7:0] tx;
        logic [2:0] sel;
        logic       loop;
        logic [7:0] slave_word;
        logic [7:0] exp_rx;
        logic [4:0] exp_cs;
        int         exp_lat;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_done(inout int cyc);
        while (!done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int   cyc;
        int   tog;
        int   last_tog;
        int   imin;
        int   imax;
        int   ival;
        logic prev_sclk;
        cpol       = v.mode.cpol;
        cpha       = v.mode.cpha;
        clk_div    = v.div;
        tx_data    = v.tx;
        cs_sel     = v.sel;
        loop_en    = v.loop;
        slave_word = v.slave_word;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check($sformatf("v%0d_busy_accept", idx), busy, 1);
        check($sformatf("v%0d_cs_n", idx), cs_n, v.exp_cs);
        check($sformatf("v%0d_sclk_idle", idx), sclk, v.mode.cpol);
        cyc = 1; tog = 0; last_tog = 0; imin = 100000; imax = 0; prev_sclk = sclk;
        while (!done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (sclk !== prev_sclk) begin
                tog++;
                if (tog > 1) begin
                    ival = cyc - last_tog;
                    if (ival < imin) imin = ival;
                    if (ival > imax) imax = ival;
                end
                last_tog  = cyc;
                prev_sclk = sclk;
            end
        end
        check($sformatf("v%0d_latency", idx), cyc, v.exp_lat);
        check($sformatf("v%0d_sclk_edges", idx), tog, 16);
        check($sformatf("v%0d_half_min", idx), imin, v.div + 1);
        check($sformatf("v%0d_half_max", idx), imax, v.div + 1);
        check($sformatf("v%0d_rx_data", idx), rx_data, v.exp_rx);
        check($sformatf("v%0d_busy_done", idx), busy, 1);
        check($sformatf("v%0d_cs_release", idx), cs_n, 5'h1F);
        check($sformatf("v%0d_sclk_end", idx), sclk, v.mode.cpol);
        if (!v.loop) check($sformatf("v%0d_slave_cap", idx), r_slv_cap, v.tx);
        @(negedge clk);
        check($sformatf("v%0d_done_pulse", idx), done, 0);
        check($sformatf("v%0d_busy_after", idx), busy, 0);
    endtask

    initial begin
        int cyc;
        int tog;
        int n_done;
        logic prev_sclk;

        rst = 1'b1; start = 1'b0; cpol = 1'b0; cpha = 1'b0; clk_div = '0;
        tx_data = '0; cs_sel = '0; loop_en = 1'b1; slave_word = 8'h00;
`ifdef SPI_LSB_FIRST_EN
        lsb_first = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_cs_n", cs_n, 5'h1F);
        check("rst_rx_data", rx_data, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);

        vecs[0] = '{mode: SPI_MODE0, div: 8'd0, tx: 8'hA5, sel: 3'd0, loop: 1'b1,
                    slave_word: 8'h00, exp_rx: 8'hA5, exp_cs: 5'b11110, exp_lat: 19};
        vecs[1] = '{mode: SPI_MODE3, div: 8'd0, tx: 8'h3C, sel: 3'd1, loop: 1'b0,
                    slave_word: 8'hC3, exp_rx: 8'hC3, exp_cs: 5'b11101, exp_lat: 19};
        vecs[2] = '{mode: SPI_MODE0, div: 8'd3, tx: 8'h5A, sel: 3'd2, loop: 1'b1,
                    slave_word: 8'h00, exp_rx: 8'h5A, exp_cs: 5'b11011, exp_lat: 73};
        vecs[3] = '{mode: SPI_MODE1, div: 8'd1, tx: 8'h96, sel: 3'd4, loop: 1'b1,
                    slave_word: 8'h00, exp_rx: 8'h96, exp_cs: 5'b01111, exp_lat: 37};
        vecs[4] = '{mode: SPI_MODE2, div: 8'd0, tx: 8'hF0, sel: 3'd5, loop: 1'b1,
                    slave_word: 8'h00, exp_rx: 8'hF0, exp_cs: 5'b11111, exp_lat: 19};

        for (int i = 0; i < 5; i++) begin
            run_vec(i, vecs[i]);
        end

        // Start pulse and clk_div change during a transfer have no effect.
        cpol = 1'b0; cpha = 1'b0; clk_div = 8'd1; tx_data = 8'h81; cs_sel = 3'd3; loop_en = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 10) begin
                start = 1'b1; tx_data = 8'hFF; clk_div = 8'd0;
            end else if (cyc == 11) begin
                start = 1'b0;
            end
        end
        check("mid_latency", cyc, 37);
        check("mid_rx_data", rx_data, 8'h81);

        // Back-to-back: start held from the done cycle is taken one cycle later.
        start = 1'b1; tx_data = 8'h3C; cs_sel = 3'd0; clk_div = 8'd0;
        @(negedge clk);
        check("b2b_busy_gap", busy, 0);
        check("b2b_done_gap", done, 0);
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy_accept", busy, 1);
        check("b2b_cs_n", cs_n, 5'b11110);
        cyc = 1;
        wait_done(cyc);
        check("b2b_latency", cyc, 19);
        check("b2b_rx_data", rx_data, 8'h3C);
        repeat (3) @(negedge clk);
        check("b2b_not_queued", busy, 0);

        // Asynchronous reset right after the seventh sclk edge.
        cpol = 1'b0; cpha = 1'b0; clk_div = 8'd0; tx_data = 8'hA5; cs_sel = 3'd0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; tog = 0; prev_sclk = sclk;
        while (tog < 7 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (sclk !== prev_sclk) begin
                tog++;
                prev_sclk = sclk;
            end
        end
        check("abort_reached_edge7", tog, 7);
        #2;
        rst = 1'b1;
        #1;
        check("abort_cs_n", cs_n, 5'h1F);
        check("abort_sclk", sclk, 0);
        check("abort_busy", busy, 0);
        check("abort_rx_data", rx_data, 0);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("abort_no_done", n_done, 0);
        check("abort_rx_kept", rx_data, 0);

`ifdef SPI_LSB_FIRST_EN
        lsb_first = 1'b1; cpol = 1'b0; cpha = 1'b0; clk_div = 8'd0; tx_data = 8'h01;
        cs_sel = 3'd0; loop_en = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("lsb_first_bit", mosi, 1);
        cyc = 1;
        wait_done(cyc);
        check("lsb_latency", cyc, 19);
        check("lsb_rx_data", rx_data, 8'h01);
        lsb_first = 1'b0;
        @(negedge clk);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
